// File: rtl/postbox_sched.sv
// Tx byte scheduler (2 requesters, burst-limited round robin) plus rx unloader for a POST engine; fully registered, ready pulses only in T_IDLE.
// Rx holds one byte until the consumer takes it, leaving pc_rxfull unserviced meanwhile; POSTBOX_SCHED_STATS_EN adds tx/rx byte counters.
module postbox_sched #(
  parameter int BURST_MAX   = 4,
  parameter int RX_WAIT_MAX = 480
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  pc_txin,
  output logic        pc_txstart,
  input  logic        pc_txempty,
  input  logic [7:0]  pc_rxout,
  input  logic        pc_rxfull,
  output logic        pc_rxreset,
  output logic        grant,
  output logic        rx_err
`ifdef POSTBOX_SCHED_STATS_EN
  ,
  output logic [15:0] tx_count,
  output logic [15:0] rx_count
`endif
);

  localparam int WAIT_W = $clog2(RX_WAIT_MAX + 1);

  typedef enum logic [1:0] {T_IDLE, T_ISSUE, T_WAIT} t_state_t;
  typedef enum logic [1:0] {R_IDLE, R_CLEAR, R_HOLD} r_state_t;

  t_state_t          t_state;
  r_state_t          r_state;
  logic [3:0]        burst_cnt;
  logic [3:0]        burst_nxt;
  logic              wait_cnt;
  logic [WAIT_W-1:0] clr_cnt;
  logic              cur_vld;
  logic              oth_vld;
  logic              sel;
  logic              tx_take;
  logic              rx_hs;

  // Stay with the grantee while it has data and burst budget; otherwise hand over if the other side wants it.
  always_comb begin
    cur_vld   = grant ? req1_valid : req0_valid;
    oth_vld   = grant ? req0_valid : req1_valid;
    sel       = grant;
    burst_nxt = 4'd1;
    if (cur_vld && (burst_cnt < 4'(BURST_MAX))) begin
      burst_nxt = burst_cnt + 4'd1;
    end else if (oth_vld) begin
      sel = ~grant;
    end
  end

  assign tx_take    = (t_state == T_IDLE) && pc_txempty && (req0_valid || req1_valid);
  assign req0_ready = tx_take && !sel;
  assign req1_ready = tx_take && sel;
  assign rx_hs      = rx_valid && rx_ready;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      t_state    <= T_IDLE;
      pc_txin    <= 8'h00;
      pc_txstart <= 1'b0;
      grant      <= 1'b0;
      burst_cnt  <= 4'd0;
      wait_cnt   <= 1'b0;
`ifdef POSTBOX_SCHED_STATS_EN
      tx_count   <= 16'h0000;
`endif
    end else begin
      case (t_state)
        T_IDLE: begin
          pc_txstart <= 1'b0;
          if (tx_take) begin
            pc_txin   <= sel ? req1_data : req0_data;
            grant     <= sel;
            burst_cnt <= burst_nxt;
            t_state   <= T_ISSUE;
`ifdef POSTBOX_SCHED_STATS_EN
            tx_count  <= tx_count + 16'h0001;
`endif
          end
        end
        T_ISSUE: begin
          pc_txstart <= 1'b1;
          wait_cnt   <= 1'b0;
          t_state    <= T_WAIT;
        end
        T_WAIT: begin
          pc_txstart <= 1'b0;
          // Engine never left empty: it missed the strobe, so strobe the same byte again.
          if (!pc_txempty) t_state <= T_IDLE;
          else if (wait_cnt) t_state <= T_ISSUE;
          else wait_cnt <= 1'b1;
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= R_IDLE;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      pc_rxreset <= 1'b0;
      rx_err     <= 1'b0;
      clr_cnt    <= '0;
`ifdef POSTBOX_SCHED_STATS_EN
      rx_count   <= 16'h0000;
`endif
    end else begin
`ifdef POSTBOX_SCHED_STATS_EN
      if (rx_hs) rx_count <= rx_count + 16'h0001;
`endif
      case (r_state)
        R_IDLE: begin
          pc_rxreset <= 1'b0;
          if (pc_rxfull) begin
            rx_data    <= pc_rxout;
            rx_valid   <= 1'b1;
            pc_rxreset <= 1'b1;
            clr_cnt    <= '0;
            r_state    <= R_CLEAR;
          end
        end
        R_CLEAR: begin
          pc_rxreset <= 1'b0;
          if (rx_hs) rx_valid <= 1'b0;
          // Byte may already be consumed here; only skip R_HOLD once the engine has dropped rxfull.
          if (!pc_rxfull) begin
            r_state <= (rx_valid && !rx_ready) ? R_HOLD : R_IDLE;
          end else if (clr_cnt == WAIT_W'(RX_WAIT_MAX - 1)) begin
            rx_err  <= 1'b1;
            r_state <= R_HOLD;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        R_HOLD: begin
          if (rx_hs) begin
            rx_valid <= 1'b0;
            r_state  <= R_IDLE;
          end else if (!rx_valid) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_postbox_sched.sv
// Directed bench for postbox_sched: tx grant/re-issue timing, rx hold/timeout, async reset.
module tb_postbox_sched;

  logic        refclk;
  logic        rst_n;
  logic [7:0]  req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  pc_txin;
  logic        pc_txstart, pc_txempty;
  logic [7:0]  pc_rxout;
  logic        pc_rxfull, pc_rxreset;
  logic        grant, rx_err;
`ifdef POSTBOX_SCHED_STATS_EN
  logic [15:0] tx_count, rx_count;
`endif

  int checks = 0;
  int errors = 0;
  int pulses;

  postbox_sched #(.BURST_MAX(4), .RX_WAIT_MAX(480)) dut (
    .refclk     (refclk),
    .rst_n      (rst_n),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .pc_txin    (pc_txin),
    .pc_txstart (pc_txstart),
    .pc_txempty (pc_txempty),
    .pc_rxout   (pc_rxout),
    .pc_rxfull  (pc_rxfull),
    .pc_rxreset (pc_rxreset),
    .grant      (grant),
    .rx_err     (rx_err)
`ifdef POSTBOX_SCHED_STATS_EN
    ,
    .tx_count   (tx_count),
    .rx_count   (rx_count)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ready"}, {14'd0, req1_ready, req0_ready}, 16'h0000);
    chk({tag, " txin"}, {8'd0, pc_txin}, 16'h0000);
    chk({tag, " rxdata"}, {8'd0, rx_data}, 16'h0000);
    chk({tag, " flags"}, {10'd0, pc_txstart, pc_rxreset, rx_valid, grant, rx_err, 1'b0}, 16'h0000);
  endtask

  localparam logic [8:0] BURST_PAT = 9'b0_1111_0000;

  initial begin
    rst_n = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; req0_valid = 1'b0; req1_valid = 1'b0;
    rx_ready = 1'b0; pc_txempty = 1'b0; pc_rxout = 8'h00; pc_rxfull = 1'b0;

    @(negedge refclk); #1;
    chk_all_zero("reset");
    @(negedge refclk);
    rst_n = 1'b1;
    @(negedge refclk);

    // Single byte from requester 0
    req0_data = 8'hA5; req0_valid = 1'b1; pc_txempty = 1'b1; #1;
    chk("t1 ready", {14'd0, req1_ready, req0_ready}, 16'h0001);
    @(negedge refclk);
    req0_valid = 1'b0; #1;
    chk("t1 txin", {8'd0, pc_txin}, 16'h00A5);
    chk("t1 grant", {15'd0, grant}, 16'h0000);
    chk("t1 start early", {15'd0, pc_txstart}, 16'h0000);
    @(negedge refclk); #1;
    chk("t1 start", {15'd0, pc_txstart}, 16'h0001);
    pc_txempty = 1'b0;
    @(negedge refclk); #1;
    chk("t1 start end", {15'd0, pc_txstart}, 16'h0000);

    // Engine stays empty: the byte from requester 1 is re-strobed every third cycle
    req1_data = 8'h5A; req1_valid = 1'b1; pc_txempty = 1'b1; #1;
    chk("t2 ready", {14'd0, req1_ready, req0_ready}, 16'h0002);
    @(negedge refclk);
    req1_valid = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      @(negedge refclk); #1;
      chk("t2 restart", {15'd0, pc_txstart}, {15'd0, (k % 3) == 2});
      chk("t2 no ready", {14'd0, req1_ready, req0_ready}, 16'h0000);
    end
    chk("t2 txin", {8'd0, pc_txin}, 16'h005A);
    chk("t2 grant", {15'd0, grant}, 16'h0001);
    pc_txempty = 1'b0;

    // Rx: capture, single reset pulse, hold while consumer stalls
    @(negedge refclk);
    pc_rxout = 8'h3C; pc_rxfull = 1'b1;
    @(negedge refclk); #1;
    chk("r1 valid", {15'd0, rx_valid}, 16'h0001);
    chk("r1 data", {8'd0, rx_data}, 16'h003C);
    chk("r1 rxreset", {15'd0, pc_rxreset}, 16'h0001);
    pc_rxfull = 1'b0;
    @(negedge refclk); #1;
    chk("r1 rxreset end", {15'd0, pc_rxreset}, 16'h0000);
    pc_rxout = 8'h99; pc_rxfull = 1'b1;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge refclk); #1;
      if (pc_rxreset) pulses++;
      chk("r1 hold valid", {15'd0, rx_valid}, 16'h0001);
    end
    chk("r1 no reset in hold", pulses[15:0], 16'h0000);
    chk("r1 held data", {8'd0, rx_data}, 16'h003C);
    rx_ready = 1'b1;
    @(negedge refclk); #1;
    chk("r1 delivered", {15'd0, rx_valid}, 16'h0000);
    rx_ready = 1'b0;
    @(negedge refclk); #1;
    chk("r2 data", {8'd0, rx_data}, 16'h0099);
    chk("r2 rxreset", {15'd0, pc_rxreset}, 16'h0001);

    // Handshake while rxfull is still high
    rx_ready = 1'b1;
    @(negedge refclk); #1;
    chk("r2 taken in clear", {15'd0, rx_valid}, 16'h0000);
    rx_ready = 1'b0; pc_rxfull = 1'b0;
    @(negedge refclk);
    pc_rxout = 8'h77; pc_rxfull = 1'b1;
    @(negedge refclk); #1;
    chk("r3 recapture", {7'd0, rx_valid, rx_data}, 16'h0177);
    pc_rxfull = 1'b0;
    @(negedge refclk);
    rx_ready = 1'b1;
    @(negedge refclk); #1;
    chk("r3 delivered", {15'd0, rx_valid}, 16'h0000);
    rx_ready = 1'b0;

    // rxfull stuck high: error after exactly 480 cycles, sticky afterwards
    pc_rxout = 8'h42; pc_rxfull = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 480; k++) begin
      @(negedge refclk); #1;
      if (pc_rxreset) pulses++;
    end
    chk("r4 err not yet", {15'd0, rx_err}, 16'h0000);
    chk("r4 one reset pulse", pulses[15:0], 16'h0001);
    @(negedge refclk); #1;
    chk("r4 err", {15'd0, rx_err}, 16'h0001);
    chk("r4 valid", {7'd0, rx_valid, rx_data}, 16'h0142);
    pc_rxfull = 1'b0; rx_ready = 1'b1;
    @(negedge refclk); #1;
    rx_ready = 1'b0;
    @(negedge refclk); #1;
    chk("r4 err sticky", {14'd0, rx_valid, rx_err}, 16'h0001);

    // Tx and rx started in the same cycle, then async reset with tx in T_WAIT and rx in R_HOLD
    @(negedge refclk);
    req1_data = 8'h66; req1_valid = 1'b1; pc_txempty = 1'b1;
    pc_rxout = 8'h44; pc_rxfull = 1'b1; #1;
    chk("t3 ready", {14'd0, req1_ready, req0_ready}, 16'h0002);
    @(negedge refclk); #1;
    chk("t3 rx", {6'd0, pc_rxreset, rx_valid, rx_data}, 16'h0344);
    chk("t3 tx", {7'd0, grant, pc_txin}, 16'h0166);
    req1_valid = 1'b0; pc_rxfull = 1'b0;
    @(negedge refclk); #1;
    chk("t3 start", {15'd0, pc_txstart}, 16'h0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
`ifdef POSTBOX_SCHED_STATS_EN
    chk("reset counters", tx_count | rx_count, 16'h0000);
`endif
    @(negedge refclk);
    @(negedge refclk);
    rst_n = 1'b1; pc_txempty = 1'b0;

    // Both requesters always valid: four bytes each, starting with requester 0
    req0_data = 8'h11; req1_data = 8'h22; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge refclk);
      pc_txempty = 1'b1; #1;
      chk("b ready", {14'd0, req1_ready, req0_ready}, BURST_PAT[i] ? 16'h0002 : 16'h0001);
      @(negedge refclk); #1;
      chk("b grant", {7'd0, grant, pc_txin}, BURST_PAT[i] ? 16'h0122 : 16'h0011);
      @(negedge refclk); #1;
      chk("b start", {15'd0, pc_txstart}, 16'h0001);
      pc_txempty = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef POSTBOX_SCHED_STATS_EN
    @(negedge refclk); #1;
    chk("tx_count", tx_count, 16'd9);
    chk("rx_count", rx_count, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/postbox_sched.md
POSTBOX_SCHED -- requirements
Module: postbox_sched

Interface
REQ-001 Parameter: BURST_MAX, 4, max consecutive tx bytes granted to one requester before rotating (1..15).
REQ-002 Parameter: RX_WAIT_MAX, 480, refclk cycles to wait for pc_rxfull to fall after pc_rxreset before flagging an error.
REQ-003 One clock; reset is asynchronous and active-low: refclk input 1 48MHz clock; rst_n input 1 async active-low reset.
REQ-004 req0_data input 8, req0_valid input 1, req0_ready output 1: requester 0 tx byte, valid/ready handshake.
REQ-005 req1_data input 8, req1_valid input 1, req1_ready output 1: requester 1 tx byte, valid/ready handshake.
REQ-006 rx_data output 8, rx_valid output 1, rx_ready input 1: received byte to consumer, valid/ready handshake.
REQ-007 pc_txin output 8, pc_txstart output 1, pc_txempty input 1: POST engine tx byte port.
REQ-008 pc_rxout input 8, pc_rxfull input 1, pc_rxreset output 1: POST engine rx byte port.
REQ-009 grant output 1 (last granted requester); rx_err output 1 (sticky, rxfull stuck high).

Function
REQ-010 Transfer on a port SHALL occur in any cycle where valid and ready are both high; ready SHALL be a single-cycle pulse, never asserted without valid.
REQ-011 Tx FSM SHALL have states T_IDLE, T_ISSUE, T_WAIT.
REQ-012 T_IDLE: when pc_txempty=1 and any reqN_valid=1, select requester, pulse its reqN_ready, latch its data into pc_txin, go T_ISSUE.
REQ-013 Selection: if current grantee still valid and burst count < BURST_MAX, keep it; otherwise, if the other is valid, rotate; otherwise keep current and reset burst count to 1.
REQ-014 Burst count SHALL increment on each accepted byte of the same grantee and reset to 1 on a grant change.
REQ-015 T_ISSUE: pc_txstart=1 for exactly one cycle with pc_txin stable; go T_WAIT.
REQ-016 T_WAIT: hold pc_txin; return to T_IDLE the first cycle pc_txempty=0; if pc_txempty stays 1 for 2 cycles, return to T_ISSUE (re-issue same byte).
REQ-017 pc_txin SHALL stay stable from T_ISSUE until the next grant.
REQ-018 Rx FSM SHALL have states R_IDLE, R_CLEAR, R_HOLD.
REQ-019 R_IDLE: when pc_rxfull=1, capture pc_rxout into rx_data, pulse pc_rxreset for one cycle, go R_CLEAR.
REQ-020 R_CLEAR: assert rx_valid; on pc_rxfull=0 go R_HOLD; if the RX_WAIT_MAX count expires first, set rx_err and go R_HOLD.
REQ-021 R_HOLD: rx_valid=1 until rx_ready=1, then go R_IDLE; a new pc_rxfull SHALL NOT be captured or reset while holding, so the engine NACKs its poll (no data loss).
REQ-022 Handshake in R_CLEAR (rx_valid & rx_ready) SHALL be accepted, with the FSM returning to R_IDLE only after pc_rxfull=0.
REQ-023 Tx and rx FSMs SHALL operate independently; simultaneous events in both SHALL both be serviced in the same cycle.
REQ-024 rx_err SHALL clear only on reset.

Reset
REQ-025 On rst_n=0, regardless of state: T_IDLE, R_IDLE, all outputs 0 (req*_ready, pc_txstart, pc_rxreset, rx_valid, rx_data, pc_txin, grant, rx_err), burst count 0.
REQ-026 Reset mid-transfer SHALL abandon the latched byte; the first grant after reset SHALL go to requester 0 when both are valid.

Configuration
REQ-027 Macro POSTBOX_SCHED_STATS_EN: when defined, add outputs tx_count[15:0] and rx_count[15:0] that count accepted tx bytes (T_ISSUE entries, excluding re-issues) and delivered rx bytes; both wrap at 0xFFFF->0 and reset to 0.
REQ-028 Without POSTBOX_SCHED_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-029 req0 valid with 0xA5, pc_txempty=1 -> req0_ready pulse, pc_txin=0xA5, one-cycle pc_txstart two cycles later; grant=0.
REQ-030 Both requesters continuously valid, BURST_MAX=4 -> grant pattern 0,0,0,0,1,1,1,1,0.
REQ-031 pc_rxfull=1 with 0x3C, rx_ready=0 for 20 cycles -> one pc_rxreset pulse; rx_data=0x3C held; second rxfull ignored until rx_ready handshake.
REQ-032 pc_rxfull held high after pc_rxreset for RX_WAIT_MAX cycles -> rx_err=1 and sticky.
REQ-033 pc_txempty held 1 after pc_txstart -> pc_txstart re-pulsed every 3 cycles with the same byte, no extra req ready.
REQ-034 rst_n asserted in T_WAIT and R_HOLD -> all outputs 0 asynchronously; counters (with POSTBOX_SCHED_STATS_EN) read 0.
